// File: rtl/tile_pair_checker.sv
// tile_pair_checker: pair-matching game core.
// The player reveals two tiles with the switches and the select key. Equal
// values lock the pair as matched. Unequal values stay on display for
// SHOW_CYCLES cycles and are then hidden again.
// Optional build macro MOVE_LIMIT_EN adds the MOVE_LIMIT parameter and the
// 'lost' output. With it, the game ends as lost once the move budget is used.
module tile_pair_checker #(
    parameter int unsigned SHOW_CYCLES = 25000000,
    parameter logic [29:0] TILE_MAP    = 30'o4433221100
`ifdef MOVE_LIMIT_EN
    ,
    parameter int unsigned MOVE_LIMIT  = 20
`endif
) (
    input  logic       CLOCK_50,
    input  logic       userquit,
    input  logic       ingameOn,
    input  logic       selectSW,
    input  logic [9:0] SW,
    output logic [9:0] ledr,
    output logic [3:0] first_val,
    output logic [3:0] second_val,
    output logic [7:0] moves,
    output logic [2:0] pairs_left,
    output logic       match_pulse,
    output logic       mismatch_pulse,
    output logic       sel_err,
    output logic       gameOver
`ifdef MOVE_LIMIT_EN
    ,
    output logic       lost
`endif
);

    localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST = (SHOW_CYCLES > 0) ? CNT_W'(SHOW_CYCLES - 1) : '0;
    localparam logic [3:0] VAL_EMPTY = 4'hF;

    typedef enum logic [2:0] {IDLE, PICK1, PICK2, COMPARE, SHOW, DONE} state_t;

    state_t           state_q, state_d;
    logic             sel_prev_q, sel_prev_d;
    logic             game_prev_q, game_prev_d;
    logic [9:0]       mask_q, mask_d;
    logic [7:0]       moves_q, moves_d;
    logic [2:0]       pairs_q, pairs_d;
    logic [3:0]       first_val_q, first_val_d;
    logic [3:0]       second_val_q, second_val_d;
    logic [3:0]       first_idx_q, first_idx_d;
    logic [3:0]       second_idx_q, second_idx_d;
    logic [CNT_W-1:0] show_cnt_q, show_cnt_d;
    logic             match_pulse_q, match_pulse_d;
    logic             mismatch_pulse_q, mismatch_pulse_d;
    logic             sel_err_q, sel_err_d;
    logic             game_over_q, game_over_d;
`ifdef MOVE_LIMIT_EN
    logic             lost_q, lost_d;
`endif

    logic       sw_onehot;
    logic [3:0] sw_idx;
    logic [3:0] sw_val;
    logic       sel_evt;
    logic       game_rise;
    logic [9:0] first_onehot;
    logic [9:0] second_onehot;
    logic       pick1_ok;
    logic       pick2_ok;
    logic [7:0] moves_inc;
    logic [2:0] pairs_dec;

    // Decode the switch bank into a tile index/value and qualify the pick
    always_comb begin
        sw_onehot = (SW != 10'd0) && ((SW & (SW - 10'd1)) == 10'd0);
        sw_idx    = 4'd0;
        sw_val    = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (SW[i]) begin
                sw_idx = 4'(i);
                sw_val = {1'b0, TILE_MAP[3*i +: 3]};
            end
        end
        sel_evt       = selectSW & ~sel_prev_q;
        game_rise     = ingameOn & ~game_prev_q;
        first_onehot  = 10'b1 << first_idx_q;
        second_onehot = 10'b1 << second_idx_q;
        pick1_ok      = sw_onehot && ((SW & mask_q) == 10'd0);
        pick2_ok      = pick1_ok && ((SW & first_onehot) == 10'd0);
        moves_inc     = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
        pairs_dec     = pairs_q - 3'd1;
    end

    // Game FSM next-state and datapath; dropping ingameOn overrides everything
    always_comb begin
        state_d          = state_q;
        sel_prev_d       = selectSW;
        game_prev_d      = ingameOn;
        mask_d           = mask_q;
        moves_d          = moves_q;
        pairs_d          = pairs_q;
        first_val_d      = first_val_q;
        second_val_d     = second_val_q;
        first_idx_d      = first_idx_q;
        second_idx_d     = second_idx_q;
        show_cnt_d       = show_cnt_q;
        match_pulse_d    = 1'b0;
        mismatch_pulse_d = 1'b0;
        sel_err_d        = 1'b0;
`ifdef MOVE_LIMIT_EN
        lost_d           = lost_q;
`endif
        if (!ingameOn) begin
            state_d      = IDLE;
            first_val_d  = VAL_EMPTY;
            second_val_d = VAL_EMPTY;
            show_cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (game_rise) begin
                        state_d      = PICK1;
                        mask_d       = 10'd0;
                        moves_d      = 8'd0;
                        pairs_d      = 3'd5;
                        first_val_d  = VAL_EMPTY;
                        second_val_d = VAL_EMPTY;
                        show_cnt_d   = '0;
`ifdef MOVE_LIMIT_EN
                        lost_d       = 1'b0;
`endif
                    end
                end
                PICK1: begin
                    if (sel_evt) begin
                        if (pick1_ok) begin
                            first_idx_d = sw_idx;
                            first_val_d = sw_val;
                            state_d     = PICK2;
                        end else begin
                            sel_err_d = 1'b1;
                        end
                    end
                end
                PICK2: begin
                    if (sel_evt) begin
                        if (pick2_ok) begin
                            second_idx_d = sw_idx;
                            second_val_d = sw_val;
                            state_d      = COMPARE;
                        end else begin
                            sel_err_d = 1'b1;
                        end
                    end
                end
                COMPARE: begin
                    moves_d = moves_inc;
                    if (first_val_q == second_val_q) begin
                        mask_d        = mask_q | first_onehot | second_onehot;
                        pairs_d       = pairs_dec;
                        match_pulse_d = 1'b1;
                        first_val_d   = VAL_EMPTY;
                        second_val_d  = VAL_EMPTY;
                        state_d       = (pairs_dec == 3'd0) ? DONE : PICK1;
                    end else begin
                        mismatch_pulse_d = 1'b1;
                        show_cnt_d       = '0;
                        state_d          = SHOW;
                    end
`ifdef MOVE_LIMIT_EN
                    if ((pairs_d != 3'd0) && (moves_d == 8'(MOVE_LIMIT))) begin
                        state_d = DONE;
                        lost_d  = 1'b1;
                    end
`endif
                end
                SHOW: begin
                    if (show_cnt_q == SHOW_LAST) begin
                        first_val_d  = VAL_EMPTY;
                        second_val_d = VAL_EMPTY;
                        show_cnt_d   = '0;
                        state_d      = PICK1;
                    end else begin
                        show_cnt_d = show_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        game_over_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLOCK_50) begin
        if (userquit) begin
            state_q          <= IDLE;
            sel_prev_q       <= 1'b0;
            game_prev_q      <= 1'b0;
            mask_q           <= 10'd0;
            moves_q          <= 8'd0;
            pairs_q          <= 3'd5;
            first_val_q      <= VAL_EMPTY;
            second_val_q     <= VAL_EMPTY;
            first_idx_q      <= 4'd0;
            second_idx_q     <= 4'd0;
            show_cnt_q       <= '0;
            match_pulse_q    <= 1'b0;
            mismatch_pulse_q <= 1'b0;
            sel_err_q        <= 1'b0;
            game_over_q      <= 1'b0;
`ifdef MOVE_LIMIT_EN
            lost_q           <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            sel_prev_q       <= sel_prev_d;
            game_prev_q      <= game_prev_d;
            mask_q           <= mask_d;
            moves_q          <= moves_d;
            pairs_q          <= pairs_d;
            first_val_q      <= first_val_d;
            second_val_q     <= second_val_d;
            first_idx_q      <= first_idx_d;
            second_idx_q     <= second_idx_d;
            show_cnt_q       <= show_cnt_d;
            match_pulse_q    <= match_pulse_d;
            mismatch_pulse_q <= mismatch_pulse_d;
            sel_err_q        <= sel_err_d;
            game_over_q      <= game_over_d;
`ifdef MOVE_LIMIT_EN
            lost_q           <= lost_d;
`endif
        end
    end

    // LEDs show matched tiles plus whichever tiles are currently face up
    always_comb begin
        ledr = mask_q;
        if (first_val_q != VAL_EMPTY) begin
            ledr = ledr | first_onehot;
        end
        if (second_val_q != VAL_EMPTY) begin
            ledr = ledr | second_onehot;
        end
    end

    assign first_val      = first_val_q;
    assign second_val     = second_val_q;
    assign moves          = moves_q;
    assign pairs_left     = pairs_q;
    assign match_pulse    = match_pulse_q;
    assign mismatch_pulse = mismatch_pulse_q;
    assign sel_err        = sel_err_q;
    assign gameOver       = game_over_q;
`ifdef MOVE_LIMIT_EN
    assign lost           = lost_q;
`endif

endmodule

// File: tb/tb_tile_pair_checker.sv
// Directed testbench for tile_pair_checker (SHOW_CYCLES=4, default tile map:
// tile i holds value i/2). With MOVE_LIMIT_EN a second instance using
// MOVE_LIMIT=3 is driven by the same inputs for the move-budget scenario.
module tb_tile_pair_checker;

    localparam int SHOW = 4;

    logic       clk = 1'b0;
    logic       userquit;
    logic       ingameOn;
    logic       selectSW;
    logic [9:0] SW;
    logic [9:0] ledr;
    logic [3:0] first_val;
    logic [3:0] second_val;
    logic [7:0] moves;
    logic [2:0] pairs_left;
    logic       match_pulse;
    logic       mismatch_pulse;
    logic       sel_err;
    logic       gameOver;
`ifdef MOVE_LIMIT_EN
    logic       lost;
    logic [9:0] limLedr;
    logic [3:0] limFirst;
    logic [3:0] limSecond;
    logic [7:0] limMoves;
    logic [2:0] limPairs;
    logic       limMatch;
    logic       limMismatch;
    logic       limSelErr;
    logic       limGameOver;
    logic       limLost;
`endif

    int   testsRun    = 0;
    int   testsFailed = 0;
    logic lastErr;
    int   nMatch;
    int   nErr;

    always #5 clk = ~clk;

    tile_pair_checker #(.SHOW_CYCLES(SHOW)) dut (
        .CLOCK_50       (clk),
        .userquit       (userquit),
        .ingameOn       (ingameOn),
        .selectSW       (selectSW),
        .SW             (SW),
        .ledr           (ledr),
        .first_val      (first_val),
        .second_val     (second_val),
        .moves          (moves),
        .pairs_left     (pairs_left),
        .match_pulse    (match_pulse),
        .mismatch_pulse (mismatch_pulse),
        .sel_err        (sel_err),
        .gameOver       (gameOver)
`ifdef MOVE_LIMIT_EN
        ,
        .lost           (lost)
`endif
    );

`ifdef MOVE_LIMIT_EN
    tile_pair_checker #(.SHOW_CYCLES(SHOW), .MOVE_LIMIT(3)) dutLim (
        .CLOCK_50       (clk),
        .userquit       (userquit),
        .ingameOn       (ingameOn),
        .selectSW       (selectSW),
        .SW             (SW),
        .ledr           (limLedr),
        .first_val      (limFirst),
        .second_val     (limSecond),
        .moves          (limMoves),
        .pairs_left     (limPairs),
        .match_pulse    (limMatch),
        .mismatch_pulse (limMismatch),
        .sel_err        (limSelErr),
        .gameOver       (limGameOver),
        .lost           (limLost)
    );
`endif

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison: count it, and report tag/observed/expected on failure
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Press and release the select key with the given switch pattern
    task automatic applyStimulus(input logic [9:0] sw);
        SW       = sw;
        selectSW = 1'b1;
        tick();
        lastErr  = sel_err;
        selectSW = 1'b0;
        tick();
    endtask

    // Drop and raise ingameOn to start a fresh game
    task automatic startGame();
        ingameOn = 1'b0;
        tick();
        ingameOn = 1'b1;
        tick();
    endtask

    // Directed scenario sequence
    initial begin
        userquit = 1'b1;
        ingameOn = 1'b0;
        selectSW = 1'b0;
        SW       = 10'd0;
        tick();
        tick();
        checkOutput("rst_ledr", 32'(ledr), 32'h000);
        checkOutput("rst_first", 32'(first_val), 32'hF);
        checkOutput("rst_second", 32'(second_val), 32'hF);
        checkOutput("rst_moves", 32'(moves), 32'd0);
        checkOutput("rst_pairs", 32'(pairs_left), 32'd5);
        checkOutput("rst_strobes", 32'({match_pulse, mismatch_pulse, sel_err}), 32'd0);
        checkOutput("rst_gameover", 32'(gameOver), 32'd0);

        userquit = 1'b0;
        ingameOn = 1'b1;
        tick();

        applyStimulus(10'h001);
        checkOutput("p1_err", 32'(lastErr), 32'd0);
        checkOutput("p1_first", 32'(first_val), 32'h0);
        checkOutput("p1_ledr", 32'(ledr), 32'h001);
        applyStimulus(10'h002);
        checkOutput("match_pulse", 32'(match_pulse), 32'd1);
        checkOutput("match_ledr", 32'(ledr), 32'h003);
        checkOutput("match_moves", 32'(moves), 32'd1);
        checkOutput("match_pairs", 32'(pairs_left), 32'd4);
        checkOutput("match_vals", 32'({first_val, second_val}), 32'hFF);
        tick();
        checkOutput("match_pulse_once", 32'(match_pulse), 32'd0);

        applyStimulus(10'h003);
        checkOutput("err_multi", 32'(lastErr), 32'd1);
        checkOutput("err_strobe_once", 32'(sel_err), 32'd0);
        applyStimulus(10'h001);
        checkOutput("err_matched", 32'(lastErr), 32'd1);
        checkOutput("err_moves", 32'(moves), 32'd1);
        applyStimulus(10'h004);
        checkOutput("p1b_err", 32'(lastErr), 32'd0);
        checkOutput("p1b_first", 32'(first_val), 32'h1);
        checkOutput("p1b_ledr", 32'(ledr), 32'h007);
        applyStimulus(10'h004);
        checkOutput("err_same", 32'(lastErr), 32'd1);
        checkOutput("err_same_moves", 32'(moves), 32'd1);
        checkOutput("err_same_first", 32'(first_val), 32'h1);

        SW       = 10'h008;
        selectSW = 1'b1;
        nMatch   = 0;
        nErr     = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            nMatch += int'(match_pulse);
            nErr   += int'(sel_err);
        end
        selectSW = 1'b0;
        tick();
        checkOutput("held_matches", 32'(nMatch), 32'd1);
        checkOutput("held_errs", 32'(nErr), 32'd0);
        checkOutput("held_moves", 32'(moves), 32'd2);
        checkOutput("held_pairs", 32'(pairs_left), 32'd3);
        checkOutput("held_ledr", 32'(ledr), 32'h00F);

        applyStimulus(10'h010);
        checkOutput("p2_first", 32'(first_val), 32'h2);
        ingameOn = 1'b0;
        tick();
        checkOutput("drop_vals", 32'({first_val, second_val}), 32'hFF);
        checkOutput("drop_moves", 32'(moves), 32'd2);
        checkOutput("drop_pairs", 32'(pairs_left), 32'd3);
        checkOutput("drop_ledr", 32'(ledr), 32'h00F);
        checkOutput("drop_gameover", 32'(gameOver), 32'd0);
        applyStimulus(10'h020);
        checkOutput("idle_err", 32'(lastErr), 32'd0);
        checkOutput("idle_first", 32'(first_val), 32'hF);

        ingameOn = 1'b1;
        tick();
        checkOutput("new_moves", 32'(moves), 32'd0);
        checkOutput("new_pairs", 32'(pairs_left), 32'd5);
        checkOutput("new_ledr", 32'(ledr), 32'h000);
        applyStimulus(10'h001);
        applyStimulus(10'h004);
        checkOutput("mis_pulse", 32'(mismatch_pulse), 32'd1);
        checkOutput("mis_moves", 32'(moves), 32'd1);
        checkOutput("mis_match", 32'(match_pulse), 32'd0);
        for (int k = 0; k < SHOW; k++) begin
            checkOutput($sformatf("show%0d_vals", k), 32'({first_val, second_val}), 32'h01);
            checkOutput($sformatf("show%0d_ledr", k), 32'(ledr), 32'h005);
            tick();
        end
        checkOutput("hide_vals", 32'({first_val, second_val}), 32'hFF);
        checkOutput("hide_ledr", 32'(ledr), 32'h000);
        checkOutput("hide_moves", 32'(moves), 32'd1);
        checkOutput("hide_pulse", 32'(mismatch_pulse), 32'd0);

        startGame();
        for (int p = 0; p < 5; p++) begin
            checkOutput($sformatf("full%0d_gameover", p), 32'(gameOver), 32'd0);
            applyStimulus(10'(1 << (2 * p)));
            applyStimulus(10'(1 << (2 * p + 1)));
            checkOutput($sformatf("full%0d_match", p), 32'(match_pulse), 32'd1);
        end
        checkOutput("done_gameover", 32'(gameOver), 32'd1);
        checkOutput("done_moves", 32'(moves), 32'd5);
        checkOutput("done_pairs", 32'(pairs_left), 32'd0);
        checkOutput("done_ledr", 32'(ledr), 32'h3FF);
        applyStimulus(10'h001);
        checkOutput("done_pick_err", 32'(lastErr), 32'd0);
        checkOutput("done_pick_first", 32'(first_val), 32'hF);
        checkOutput("done_hold_moves", 32'(moves), 32'd5);
        checkOutput("done_hold_gameover", 32'(gameOver), 32'd1);

        startGame();
        applyStimulus(10'h001);
        applyStimulus(10'h004);
        tick();
        checkOutput("pre_quit_moves", 32'(moves), 32'd1);
        userquit = 1'b1;
        tick();
        checkOutput("quit_vals", 32'({first_val, second_val}), 32'hFF);
        checkOutput("quit_ledr", 32'(ledr), 32'h000);
        checkOutput("quit_moves", 32'(moves), 32'd0);
        checkOutput("quit_pairs", 32'(pairs_left), 32'd5);
        checkOutput("quit_strobes", 32'({match_pulse, mismatch_pulse, sel_err}), 32'd0);
        checkOutput("quit_gameover", 32'(gameOver), 32'd0);
        userquit = 1'b0;
        tick();

`ifdef MOVE_LIMIT_EN
        startGame();
        for (int m = 0; m < 2; m++) begin
            applyStimulus(10'h001);
            applyStimulus(10'h004);
            checkOutput($sformatf("lim%0d_gameover", m), 32'(limGameOver), 32'd0);
            for (int k = 0; k < SHOW; k++) begin
                tick();
            end
        end
        applyStimulus(10'h001);
        applyStimulus(10'h004);
        checkOutput("lim_lost", 32'(limLost), 32'd1);
        checkOutput("lim_gameover", 32'(limGameOver), 32'd1);
        checkOutput("lim_moves", 32'(limMoves), 32'd3);
        checkOutput("lim_main_lost", 32'(lost), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
